// File: rtl/muldiv_seq_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_func_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide: radix-2 shift-add and restoring divide
// on unsigned magnitudes, with sign fix-up in a dedicated cycle.
//   state  | meaning
//   IDLE   | waiting for StartE
//   CALC   | one iteration per cycle, XLEN cycles
//   FIX    | sign correction and result select into MDResultE
//   DONE   | DoneE pulse, still busy
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic            CLK,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      MDFuncE,
  input  logic [XLEN-1:0] OpA,
  input  logic [XLEN-1:0] OpB,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] MDResultE
);

  state_e           state_q, state_d;
  md_func_e         func_q, func_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
  logic             neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d;

  md_func_e        func_in;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum, rem_sh, trial;
  logic [XLEN-1:0] prod_hi_fix, prod_lo_fix, quot_fix, rem_fix;

  // hi holds the upper product / partial remainder, lo the multiplier / quotient
  always_comb begin
    func_in = md_func_e'(MDFuncE);
    sgn_a   = OpA[XLEN-1] & (func_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sgn_b   = OpB[XLEN-1] & (func_in inside {MD_MULH, MD_DIV, MD_REM});
    abs_a   = cond_neg(OpA, sgn_a);
    abs_b   = cond_neg(OpB, sgn_b);
    mul_sum = {1'b0, hi_q} + {1'b0, opnd_q};
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, opnd_q};
    prod_lo_fix = cond_neg(lo_q, neg_q);
    prod_hi_fix = (neg_q && (lo_q != '0)) ? ~hi_q : cond_neg(hi_q, neg_q);
    quot_fix    = dz_q ? '1 : cond_neg(lo_q, neg_q);
    rem_fix     = cond_neg(hi_q, neg_rem_q);
  end

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    res_d     = res_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (StartE && !FlushE) begin
          state_d   = S_CALC;
          func_d    = func_in;
          cnt_d     = '0;
          hi_d      = '0;
          lo_d      = MDFuncE[2] ? abs_a : abs_b;
          opnd_d    = MDFuncE[2] ? abs_b : abs_a;
          neg_d     = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          dz_d      = (OpB == '0);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (func_q[2]) begin
          hi_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ~trial[XLEN]};
        end else if (lo_q[0]) begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[XLEN-1:1]};
          lo_d = {hi_q[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        case (func_q)
          MD_MUL:                        res_d = prod_lo_fix;
          MD_MULH, MD_MULHSU, MD_MULHU:  res_d = prod_hi_fix;
          MD_DIV, MD_DIVU:               res_d = quot_fix;
          MD_REM, MD_REMU:               res_d = rem_fix;
          default:                       res_d = res_q;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // an aborted op must leave the previous result visible
    if (FlushE && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      func_q    <= MD_MUL;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      res_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      res_q     <= res_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BusyE     = busy_q;
  assign DoneE     = done_q;
  assign MDResultE = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results queued at issue, popped on DoneE.
module tb_muldiv_seq;

  logic        CLK = 1'b0;
  logic        reset, StartE, FlushE, BusyE, DoneE;
  logic [2:0]  MDFuncE;
  logic [31:0] OpA, OpB, MDResultE;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'h0;

  always #5 CLK = ~CLK;

  muldiv_seq dut (
    .CLK(CLK), .reset(reset), .StartE(StartE), .MDFuncE(MDFuncE),
    .OpA(OpA), .OpB(OpB), .FlushE(FlushE),
    .BusyE(BusyE), .DoneE(DoneE), .MDResultE(MDResultE)
  );

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib;
    ua = {32'h0, a}; ub = {32'h0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return ia / ib;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            else return ia % ib;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // called on a falling edge; returns on the falling edge after the accepting edge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    MDFuncE = f; OpA = a; OpB = b; StartE = 1'b1;
    @(negedge CLK);
    StartE = 1'b0;
  endtask

  // edges counts the accepting edge as 1
  task automatic wait_done(output int edges, output int busy_cyc, output bit seen);
    edges = 1; busy_cyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (BusyE) busy_cyc++;
      if (DoneE) begin seen = 1'b1; break; end
      @(negedge CLK);
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; MDFuncE = 3'd0; OpA = '0; OpB = '0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({BusyE, DoneE} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctrl: BusyE/DoneE=%b expected 00", {BusyE, DoneE});
    end
    n_tests++;
    if (MDResultE !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 00000000", MDResultE);
    end
  endtask

  task automatic test_mul_timing();
    int edges, busy; bit seen; logic [31:0] e;
    exp_q.push_back(32'hFFFF_FFEB);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_done(edges, busy, seen);
    n_tests++;
    if (!seen || edges !== 34) begin
      n_fail++; $display("FAIL mul_latency: done after %0d edges (seen=%0b) expected 34", edges, seen);
    end
    n_tests++;
    if (busy !== 34) begin
      n_fail++; $display("FAIL mul_busy: busy for %0d cycles expected 34", busy);
    end
    e = exp_q.pop_front(); last_res = e;
    n_tests++;
    if (MDResultE !== e) begin
      n_fail++; $display("FAIL mul_result: got %h expected %h", MDResultE, e);
    end
    @(negedge CLK);
    n_tests++;
    if ({BusyE, DoneE} !== 2'b00) begin
      n_fail++; $display("FAIL mul_after_done: BusyE/DoneE=%b expected 00", {BusyE, DoneE});
    end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f[4] = '{3'd3, 3'd1, 3'd2, 3'd0};
    logic [31:0] r[4] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    int edges, busy; bit seen; logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      exp_q.push_back(r[i]);
      issue(f[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(edges, busy, seen);
      e = exp_q.pop_front(); last_res = e;
      n_tests++;
      if (!seen || MDResultE !== e || edges !== 34) begin
        n_fail++; $display("FAIL mulh[%0d]: got %h after %0d edges expected %h after 34", i, MDResultE, edges, e);
      end
    end
  endtask

  task automatic test_div_signs();
    logic [2:0]  f[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] r[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
    int edges, busy; bit seen; logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      exp_q.push_back(r[i]);
      issue(f[i], 32'hFFFF_FFF9, 32'd2);
      wait_done(edges, busy, seen);
      e = exp_q.pop_front(); last_res = e;
      n_tests++;
      if (!seen || MDResultE !== e || edges !== 34) begin
        n_fail++; $display("FAIL div_signs[%0d]: got %h after %0d edges expected %h after 34", i, MDResultE, edges, e);
      end
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f[6] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] a[6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] b[6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] r[6] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    int edges, busy; bit seen; logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      exp_q.push_back(r[i]);
      issue(f[i], a[i], b[i]);
      wait_done(edges, busy, seen);
      e = exp_q.pop_front(); last_res = e;
      n_tests++;
      if (!seen || MDResultE !== e || edges !== 34) begin
        n_fail++; $display("FAIL div_special[%0d]: got %h after %0d edges expected %h after 34", i, MDResultE, edges, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy; bit seen; logic [31:0] e;
    @(negedge CLK);
    exp_q.push_back(32'h0000_000C);
    issue(3'd0, 32'd3, 32'd4);
    repeat (3) @(negedge CLK);
    MDFuncE = 3'd4; OpA = 32'd99; OpB = 32'd7; StartE = 1'b1;
    @(negedge CLK);
    StartE = 1'b0;
    wait_done(edges, busy, seen);
    e = exp_q.pop_front(); last_res = e;
    n_tests++;
    if (!seen || MDResultE !== e) begin
      n_fail++; $display("FAIL ignore_start: got %h (seen=%0b) expected %h", MDResultE, seen, e);
    end
    // StartE raised in the DONE cycle and held one more cycle
    exp_q.push_back(32'd30);
    MDFuncE = 3'd0; OpA = 32'd5; OpB = 32'd6; StartE = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (BusyE !== 1'b0 || MDResultE !== last_res) begin
      n_fail++; $display("FAIL done_cycle_start: BusyE=%b result %h expected 0 and %h", BusyE, MDResultE, last_res);
    end
    @(negedge CLK);
    StartE = 1'b0;
    n_tests++;
    if (BusyE !== 1'b1) begin
      n_fail++; $display("FAIL next_cycle_start: BusyE=%b expected 1", BusyE);
    end
    wait_done(edges, busy, seen);
    e = exp_q.pop_front(); last_res = e;
    n_tests++;
    if (!seen || MDResultE !== e || edges !== 34) begin
      n_fail++; $display("FAIL retry_result: got %h after %0d edges expected %h after 34", MDResultE, edges, e);
    end
  endtask

  task automatic test_random();
    int edges, busy; bit seen; logic [31:0] a, b, e; logic [2:0] f;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      n_tests++;
      if (BusyE !== 1'b0) begin
        n_fail++; $display("FAIL rand_idle[%0d]: BusyE=%b expected 0", i, BusyE);
      end
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      exp_q.push_back(model(f, a, b));
      issue(f, a, b);
      wait_done(edges, busy, seen);
      e = exp_q.pop_front(); last_res = e;
      n_tests++;
      if (!seen || MDResultE !== e || edges !== 34) begin
        n_fail++; $display("FAIL rand[%0d] f=%0d a=%h b=%h: got %h after %0d edges expected %h", i, f, a, b, MDResultE, edges, e);
      end
    end
  endtask

  task automatic test_flush();
    int dones;
    @(negedge CLK);
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (9) @(negedge CLK);
    FlushE = 1'b1;
    @(negedge CLK);
    FlushE = 1'b0;
    n_tests++;
    if ({BusyE, DoneE} !== 2'b00 || MDResultE !== last_res) begin
      n_fail++; $display("FAIL flush: BusyE/DoneE=%b result %h expected 00 and %h", {BusyE, DoneE}, MDResultE, last_res);
    end
    dones = 0;
    repeat (40) begin @(negedge CLK); if (DoneE || BusyE) dones++; end
    n_tests++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL flush_quiet: %0d busy/done cycles expected 0", dones);
    end
    MDFuncE = 3'd0; OpA = 32'd2; OpB = 32'd2; StartE = 1'b1; FlushE = 1'b1;
    @(negedge CLK);
    StartE = 1'b0; FlushE = 1'b0;
    n_tests++;
    if (BusyE !== 1'b0) begin
      n_fail++; $display("FAIL flush_cancels_start: BusyE=%b expected 0", BusyE);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge CLK);
    issue(3'd4, 32'd1000, 32'd7);
    repeat (19) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    n_tests++;
    if ({BusyE, DoneE} !== 2'b00 || MDResultE !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: BusyE/DoneE=%b result %h expected 00 and 00000000", {BusyE, DoneE}, MDResultE);
    end
    last_res = 32'h0;
    dones = 0;
    repeat (40) begin @(negedge CLK); if (DoneE) dones++; end
    n_tests++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL reset_mid_quiet: %0d done pulses expected 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_div_signs();
    test_div_special();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
